// File: rtl/stk_pkg.sv
// Shared definitions for the stack unit and its push/pop sequencer:
// default geometry, pointer-width helper and the strobe-event encoding.
package stk_pkg;

    localparam int DATA_LEN_DEF = 8;
    localparam int DEPTH_DEF    = 16;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int ptr_len_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Strobe events seen in one clock cycle, encoded {pop, push}.
    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_PUSH = 2'b01,
        EV_POP  = 2'b10,
        EV_BOTH = 2'b11
    } stk_ev_e;

endpackage

// File: rtl/strobe_edge.sv
// Rising-edge detector for one bus strobe. Only a solid logic 1 counts
// as asserted. The previous-value register resets to 1, so a strobe that
// is already high when reset releases must drop before it can fire.
module strobe_edge (
    input  logic clk,
    input  logic rstn,
    input  logic in,
    output logic pulse
);

    logic w_in_one;
    logic r_prev;

    // 0, x and z all read as deasserted; in hardware this is a plain compare.
    assign w_in_one = (in === 1'b1);

    // Remember last cycle's strobe level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_in_one;
        end
    end

    assign pulse = w_in_one & ~r_prev;

endmodule

// File: rtl/stack_unit.sv
// LIFO responder on the push/pop bus. Push stores stk_data_in; pop loads
// the removed word into the registered stk_data_out one cycle after the
// strobe edge. Reports occupancy, full and empty.
// Optional build macro STACK_ERR_EN adds sticky ovf/unf error flags;
// without it both flags are tied to 0 and err_clr is ignored.
module stack_unit
    import stk_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PTR_LEN  = ptr_len_f(DEPTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stk_push,
    input  logic                stk_pop,
    input  logic [DATA_LEN-1:0] stk_data_in,
    output logic [DATA_LEN-1:0] stk_data_out,
    output logic [DATA_LEN-1:0] top,
    output logic [PTR_LEN:0]    count,
    output logic                empty,
    output logic                full,
    input  logic                err_clr,
    output logic                ovf,
    output logic                unf
);

    localparam logic [PTR_LEN:0]   CNT_FULL = (PTR_LEN+1)'(DEPTH);
    localparam logic [PTR_LEN:0]   CNT_ONE  = (PTR_LEN+1)'(1);
    localparam logic [PTR_LEN-1:0] PTR_ONE  = PTR_LEN'(1);

    logic [DATA_LEN-1:0] r_mem [DEPTH];
    logic [PTR_LEN-1:0]  r_sp;
    logic [PTR_LEN:0]    r_count;
    logic [DATA_LEN-1:0] r_data_out;

    logic                w_push_ev;
    logic                w_pop_ev;
    stk_ev_e             w_ev;
    logic                w_full;
    logic                w_empty;
    logic [PTR_LEN-1:0]  w_sp_m1;
    logic [PTR_LEN-1:0]  w_sp_nxt;
    logic [PTR_LEN:0]    w_cnt_nxt;
    logic [DATA_LEN-1:0] w_dout_nxt;
    logic                w_wr_en;
    logic [PTR_LEN-1:0]  w_wr_addr;
    logic                w_ovf_set;
    logic                w_unf_set;

    strobe_edge u_push_edge (
        .clk   (clk),
        .rstn  (rstn),
        .in    (stk_push),
        .pulse (w_push_ev)
    );

    strobe_edge u_pop_edge (
        .clk   (clk),
        .rstn  (rstn),
        .in    (stk_pop),
        .pulse (w_pop_ev)
    );

    assign w_ev    = stk_ev_e'({w_pop_ev, w_push_ev});
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_sp_m1 = r_sp - PTR_ONE;

    // Decide the next stack state from this cycle's strobe events.
    always_comb begin
        w_sp_nxt   = r_sp;
        w_cnt_nxt  = r_count;
        w_dout_nxt = r_data_out;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_sp;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        case (w_ev)
            EV_NONE: begin
                w_sp_nxt = r_sp;
            end
            EV_PUSH: begin
                if (!w_full) begin
                    w_wr_en   = 1'b1;
                    w_sp_nxt  = r_sp + PTR_ONE;
                    w_cnt_nxt = r_count + CNT_ONE;
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
            EV_POP: begin
                if (!w_empty) begin
                    w_dout_nxt = r_mem[w_sp_m1];
                    w_sp_nxt   = w_sp_m1;
                    w_cnt_nxt  = r_count - CNT_ONE;
                end else begin
                    w_unf_set = 1'b1;
                end
            end
            EV_BOTH: begin
                // Replace the top in place, or pass the word straight through
                // when there is nothing stacked. Neither case is an error.
                if (!w_empty) begin
                    w_dout_nxt = r_mem[w_sp_m1];
                    w_wr_en    = 1'b1;
                    w_wr_addr  = w_sp_m1;
                end else begin
                    w_dout_nxt = stk_data_in;
                end
            end
            default: begin
                w_sp_nxt = r_sp;
            end
        endcase
    end

    // Stack pointer, occupancy and popped-word registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sp       <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            r_sp       <= w_sp_nxt;
            r_count    <= w_cnt_nxt;
            r_data_out <= w_dout_nxt;
        end
    end

    // Storage array; deliberately not reset, contents valid once written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= stk_data_in;
        end
    end

`ifdef STACK_ERR_EN
    logic r_ovf;
    logic r_unf;

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (err_clr) begin
                r_unf <= 1'b0;
            end else begin
                r_unf <= r_unf;
            end
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`else
    logic w_unused_err;
    assign w_unused_err = err_clr ^ w_ovf_set ^ w_unf_set;
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    assign stk_data_out = r_data_out;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign top          = w_empty ? '0 : r_mem[w_sp_m1];

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: a driver issues directed then random
// strobe patterns and updates a queue-based LIFO model; each cycle's
// expected outputs go into a scoreboard that a negedge monitor drains.
module tb_stack_unit;
    import stk_pkg::*;

    localparam int DL = 8;
    localparam int DP = 16;
    localparam int PL = $clog2(DP);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          stk_push = 1'b0;
    logic          stk_pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [DL-1:0] stk_data_in = '0;
    logic [DL-1:0] stk_data_out;
    logic [DL-1:0] top;
    logic [PL:0]   count;
    logic          empty, full, ovf, unf;

    stack_unit #(.DATA_LEN(DL), .DEPTH(DP)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .top          (top),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .err_clr      (err_clr),
        .ovf          (ovf),
        .unf          (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DL-1:0] dout;
        logic [DL-1:0] top;
        int            cnt;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    // Reference model: a plain LIFO queue plus last popped word and flags.
    logic [DL-1:0] m_stk[$];
    logic [DL-1:0] m_dout = '0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            m_prev_push = 1'b1;
    bit            m_prev_pop = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t snap(input int due);
        exp_t e;
        e.due   = due;
        e.dout  = m_dout;
        e.cnt   = m_stk.size();
        e.top   = (m_stk.size() > 0) ? m_stk[$] : 8'h00;
        e.full  = (m_stk.size() == DP);
        e.empty = (m_stk.size() == 0);
`ifdef STACK_ERR_EN
        e.ovf   = m_ovf;
        e.unf   = m_unf;
`else
        e.ovf   = 1'b0;
        e.unf   = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against every scoreboard entry due now.
    exp_t me;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            me = sb.pop_front();
            if (me.due < cyc) begin
                chk("stale_entry", 32'(cyc), 32'(me.due));
            end else begin
                chk("stk_data_out", 32'(stk_data_out), 32'(me.dout));
                chk("top",          32'(top),          32'(me.top));
                chk("count",        32'(count),        32'(me.cnt));
                chk("full",         32'(full),         32'(me.full));
                chk("empty",        32'(empty),        32'(me.empty));
                chk("ovf",          32'(ovf),          32'(me.ovf));
                chk("unf",          32'(unf),          32'(me.unf));
            end
        end
    end

    // Drive one clock cycle of strobes and record the resulting expectation.
    task automatic step(input bit push, input bit pop, input logic [DL-1:0] din, input bit clr);
        bit ev_push, ev_pop, oset, uset;
        @(posedge clk); #1;
        stk_push = push;
        stk_pop = pop;
        stk_data_in = din;
        err_clr = clr;
        ev_push = push && !m_prev_push;
        ev_pop  = pop && !m_prev_pop;
        m_prev_push = push;
        m_prev_pop  = pop;
        oset = 1'b0;
        uset = 1'b0;
        if (ev_push && ev_pop) begin
            if (m_stk.size() > 0) begin
                m_dout = m_stk.pop_back();
                m_stk.push_back(din);
            end else begin
                m_dout = din;
            end
        end else if (ev_push) begin
            if (m_stk.size() < DP) m_stk.push_back(din);
            else oset = 1'b1;
        end else if (ev_pop) begin
            if (m_stk.size() > 0) m_dout = m_stk.pop_back();
            else uset = 1'b1;
        end
        if (oset) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (uset) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        sb.push_back(snap(cyc + 1));
    endtask

    task automatic push_val(input logic [DL-1:0] v);
        step(1'b1, 1'b0, v, 1'b0);
        step(1'b0, 1'b0, v, 1'b0);
    endtask

    task automatic pop_once();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Assert reset after the pending edge has been checked, hold it, release.
    task automatic do_reset();
        @(posedge clk);
        @(negedge clk); #1;
        rstn = 1'b0;
        m_stk.delete();
        m_dout = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        sb.push_back(snap(cyc + 1));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_prev_push = (stk_push === 1'b1);
        m_prev_pop  = (stk_pop === 1'b1);
    endtask

    initial begin
        do_reset();

        // Basic LIFO order.
        push_val(8'h11);
        push_val(8'h22);
        push_val(8'h33);
        repeat (3) pop_once();

        // Pop held high for two cycles is a single pop.
        push_val(8'h5A);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill, then overflow.
        for (int i = 0; i < DP; i++) push_val(8'(i));
        push_val(8'hFF);
        repeat (DP) pop_once();

        // Underflow, then clear on the following cycle.
        pop_once();
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Replace with top 0x07 and three entries, then pass-through when empty.
        push_val(8'h05);
        push_val(8'h06);
        push_val(8'h07);
        step(1'b1, 1'b1, 8'h44, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) pop_once();
        step(1'b1, 1'b1, 8'h44, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset mid-operation with push held high.
        for (int i = 0; i < 4; i++) push_val(8'hA0 + 8'(i));
        step(1'b1, 1'b0, 8'hA4, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 8'hB0, 1'b0);
        step(1'b1, 1'b0, 8'hB1, 1'b0);
        step(1'b0, 1'b0, 8'hB2, 1'b0);
        step(1'b1, 1'b0, 8'hAB, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Random traffic, biased toward pushes in the first half.
        for (int i = 0; i < 400; i++) begin
            bit p, q, c;
            p = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            q = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            step(p, q, 8'($urandom_range(0, 255)), c);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
